// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - 8-channel memory-mapped LED PWM controller with double-buffered duty
module led_pwm #(
    parameter logic [7:0] RESET_PRESCALER = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [7:0]  leds_out
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DUTY_LO = 2'd1;
    localparam logic [1:0] REG_DUTY_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic        enable;
    logic [7:0]  presc;
    logic [7:0]  pcnt;
    logic [7:0]  cnt;
    logic        wrap;
    // Channel i duty lives in bits [8*i+7:8*i]; low word is DUTY_LO, high word DUTY_HI.
    logic [63:0] shadow;
    logic [63:0] active;

    logic [1:0]  reg_sel;
    logic        tick;
    logic        wrap_tick;
    logic        wrap_clear;
    logic        unused_inputs;

    assign reg_sel    = address_in[3:2];
    // The >= (not ==) makes a prescaler shrink below pcnt tick at once instead of running through 255.
    assign tick       = enable && (pcnt >= presc);
    assign wrap_tick  = tick && (cnt == 8'hff);
    assign wrap_clear = sel_in && (reg_sel == REG_STATUS) && write_mask_in[1] && write_value_in[8];
    assign ready_out  = sel_in;

    // Reads have no side effects, so the strobe and undecoded address bits are not needed.
    assign unused_inputs = ^{read_in, address_in[31:4], address_in[1:0]};

    // CTRL register: enable and prescaler reload, each byte lane written independently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable <= 1'b0;
            presc  <= RESET_PRESCALER;
        end else if (sel_in && (reg_sel == REG_CTRL)) begin
            if (write_mask_in[0]) enable <= write_value_in[0];
            if (write_mask_in[1]) presc  <= write_value_in[15:8];
        end
    end

    // Bus-visible shadow duty values, one byte lane per channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (sel_in) begin
            for (int b = 0; b < 4; b++) begin
                if (write_mask_in[b] && (reg_sel == REG_DUTY_LO))
                    shadow[8*b +: 8] <= write_value_in[8*b +: 8];
                if (write_mask_in[b] && (reg_sel == REG_DUTY_HI))
                    shadow[32 + 8*b +: 8] <= write_value_in[8*b +: 8];
            end
        end
    end

    // Compare duty: tracks shadow while disabled, otherwise reloads only at the period wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= '0;
        end else if (!enable || wrap_tick) begin
            active <= shadow;
        end
    end

    // Prescaler and period counters, held at zero while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (!enable) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            cnt  <= cnt + 8'd1;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    // Sticky wrap flag; a set on the wrap tick beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else if (wrap_tick) begin
            wrap <= 1'b1;
        end else if (wrap_clear) begin
            wrap <= 1'b0;
        end
    end

    // Registered PWM compare against the pre-edge counter and active duty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_out <= '0;
        end else if (!enable) begin
            leds_out <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                leds_out[i] <= (cnt < active[8*i +: 8]);
            end
        end
    end

    // Single-cycle read mux; drives zero when not selected so the bus can OR slaves
    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            case (reg_sel)
                REG_CTRL:    read_value_out = {16'h0000, presc, 7'h00, enable};
                REG_DUTY_LO: read_value_out = shadow[31:0];
                REG_DUTY_HI: read_value_out = shadow[63:32];
                default:     read_value_out = {23'h000000, wrap, leds_out};
            endcase
        end
    end

endmodule
